// File: rtl/draw_layer_arbiter.sv
// Per-pixel priority arbiter for the VGA colour path: grants the highest-priority
// enabled layer, registers the colour, and gathers per-frame collision masks.
module draw_layer_arbiter #(
   parameter int                    NUM_LAYERS = 4,
   parameter logic [11:0]           BG_RGB     = 12'h000,
   parameter logic [NUM_LAYERS-1:0] EN_RESET   = {NUM_LAYERS{1'b1}}
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       frame_start,
   input  logic                       pxl_valid,
   input  logic [NUM_LAYERS-1:0]      draw_req,
   input  logic [12*NUM_LAYERS-1:0]   rgb_in,
   input  logic                       cfg_we,
   input  logic [NUM_LAYERS-1:0]      cfg_en,
   output logic [3:0]                 Red,
   output logic [3:0]                 Green,
   output logic [3:0]                 Blue,
   output logic                       Drawing,
   output logic [2:0]                 owner,
   output logic                       coll_now,
   output logic [NUM_LAYERS-1:0]      coll_frame,
   output logic                       coll_irq
);

   localparam logic [NUM_LAYERS-1:0] ONE = {{(NUM_LAYERS-1){1'b0}}, 1'b1};

   logic [NUM_LAYERS-1:0] en_active;
   logic [NUM_LAYERS-1:0] en_pending;
   logic [NUM_LAYERS-1:0] coll_acc;

   logic [NUM_LAYERS-1:0] eff;
   logic                  multi_hit;
   logic                  grant_any;
   logic [2:0]            grant_idx;
   logic [11:0]           grant_rgb;

   // Scanning from the lowest priority upward lets the lowest index overwrite last.
   always_comb begin
      eff       = draw_req & en_active & {NUM_LAYERS{pxl_valid}};
      multi_hit = |(eff & (eff - ONE));
      grant_any = 1'b0;
      grant_idx = 3'd0;
      grant_rgb = BG_RGB;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (eff[i]) begin
            grant_any = 1'b1;
            grant_idx = 3'(i);
            grant_rgb = rgb_in[12*i +: 12];
         end
      end
   end

   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         Red      <= BG_RGB[11:8];
         Green    <= BG_RGB[7:4];
         Blue     <= BG_RGB[3:0];
         Drawing  <= 1'b0;
         owner    <= 3'd0;
         coll_now <= 1'b0;
      end else begin
         Red      <= grant_rgb[11:8];
         Green    <= grant_rgb[7:4];
         Blue     <= grant_rgb[3:0];
         Drawing  <= grant_any;
         owner    <= grant_idx;
         coll_now <= multi_hit;
      end
   end

   // On a frame boundary the new frame's first pixel seeds the accumulator.
   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         coll_acc   <= '0;
         coll_frame <= '0;
         coll_irq   <= 1'b0;
      end else if (frame_start) begin
         coll_frame <= coll_acc;
         coll_irq   <= |coll_acc;
         coll_acc   <= multi_hit ? eff : '0;
      end else begin
         coll_irq <= 1'b0;
         if (multi_hit)
            coll_acc <= coll_acc | eff;
      end
   end

   // A write coinciding with frame_start bypasses the pending register.
   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         en_pending <= EN_RESET;
         en_active  <= EN_RESET;
      end else begin
         if (cfg_we)
            en_pending <= cfg_en;
         if (frame_start)
            en_active <= cfg_we ? cfg_en : en_pending;
      end
   end

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Scoreboard bench for draw_layer_arbiter: directed vectors push hand-computed
// responses into a queue that a monitor pops one cycle later.
module tb_draw_layer_arbiter;

   localparam int N = 4;

   typedef struct packed {
      logic          drawing;
      logic [2:0]    owner;
      logic [11:0]   rgb;
      logic          coll_now;
      logic [N-1:0]  coll_frame;
      logic          coll_irq;
      logic [7:0]    tag;
   } exp_t;

   logic            clk = 1'b0;
   logic            resetN;
   logic            frame_start;
   logic            pxl_valid;
   logic [N-1:0]    draw_req;
   logic [12*N-1:0] rgb_in;
   logic            cfg_we;
   logic [N-1:0]    cfg_en;
   logic [3:0]      Red, Green, Blue;
   logic            Drawing;
   logic [2:0]      owner;
   logic            coll_now;
   logic [N-1:0]    coll_frame;
   logic            coll_irq;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;

   draw_layer_arbiter #(.NUM_LAYERS(N), .BG_RGB(12'h000), .EN_RESET(4'b1111)) dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start), .pxl_valid(pxl_valid),
      .draw_req(draw_req), .rgb_in(rgb_in), .cfg_we(cfg_we), .cfg_en(cfg_en),
      .Red(Red), .Green(Green), .Blue(Blue), .Drawing(Drawing), .owner(owner),
      .coll_now(coll_now), .coll_frame(coll_frame), .coll_irq(coll_irq)
   );

   always #5 clk = ~clk;

   task automatic checkField(input string name, input int tag, input logic [15:0] act,
                             input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s vec%0d: got %h, expected %h", name, tag, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkField("Drawing", e.tag, 16'(Drawing), 16'(e.drawing));
      checkField("owner", e.tag, 16'(owner), 16'(e.owner));
      checkField("rgb", e.tag, 16'({Red, Green, Blue}), 16'(e.rgb));
      checkField("coll_now", e.tag, 16'(coll_now), 16'(e.coll_now));
      checkField("coll_frame", e.tag, 16'(coll_frame), 16'(e.coll_frame));
      checkField("coll_irq", e.tag, 16'(coll_irq), 16'(e.coll_irq));
   endtask

   // Inputs go in at the falling edge; the expected response is queued alongside.
   task automatic applyStimulus(input int tag, input logic fs, input logic pv,
                                input logic [N-1:0] req, input logic we,
                                input logic [N-1:0] cen, input logic e_draw,
                                input logic [2:0] e_own, input logic [11:0] e_rgb,
                                input logic e_cn, input logic [N-1:0] e_cf,
                                input logic e_irq);
      exp_t e;
      @(negedge clk);
      frame_start = fs;
      pxl_valid   = pv;
      draw_req    = req;
      cfg_we      = we;
      cfg_en      = cen;
      e = '{drawing: e_draw, owner: e_own, rgb: e_rgb, coll_now: e_cn,
            coll_frame: e_cf, coll_irq: e_irq, tag: 8'(tag)};
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checkOutput(cur);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      exp_t r;
      resetN      = 1'b1;
      frame_start = 1'b0;
      pxl_valid   = 1'b0;
      draw_req    = '0;
      cfg_we      = 1'b0;
      cfg_en      = '0;
      // layer3=0F0, layer2=0A5, layer1=F00, layer0=00F
      rgb_in      = {12'h0F0, 12'h0A5, 12'hF00, 12'h00F};
      #12;
      resetN = 1'b0;
      #1;
      r = '{drawing: 1'b0, owner: 3'd0, rgb: 12'h000, coll_now: 1'b0,
            coll_frame: 4'b0000, coll_irq: 1'b0, tag: 8'd0};
      checkOutput(r);

      //            tag fs pv req     we cen      dr own rgb      cn cf       irq
      applyStimulus( 1, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus( 2, 0, 1, 4'b1010, 0, 4'b0000, 1, 1, 12'hF00, 1, 4'b0000, 0);
      applyStimulus( 3, 0, 1, 4'b1000, 0, 4'b0000, 1, 3, 12'h0F0, 0, 4'b0000, 0);
      applyStimulus( 4, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b1010, 1);
      applyStimulus( 5, 0, 1, 4'b0101, 0, 4'b0000, 1, 0, 12'h00F, 1, 4'b1010, 0);
      applyStimulus( 6, 0, 1, 4'b0110, 0, 4'b0000, 1, 1, 12'hF00, 1, 4'b1010, 0);
      applyStimulus( 7, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b1010, 0);
      applyStimulus( 8, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0111, 1);
      applyStimulus( 9, 0, 1, 4'b0001, 0, 4'b0000, 1, 0, 12'h00F, 0, 4'b0111, 0);
      applyStimulus(10, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      // Deferred enable: layer 0 keeps winning until the frame boundary.
      applyStimulus(11, 0, 1, 4'b0011, 1, 4'b1110, 1, 0, 12'h00F, 1, 4'b0000, 0);
      applyStimulus(12, 0, 1, 4'b0011, 0, 4'b0000, 1, 0, 12'h00F, 1, 4'b0000, 0);
      applyStimulus(13, 1, 1, 4'b0011, 0, 4'b0000, 1, 0, 12'h00F, 1, 4'b0011, 1);
      applyStimulus(14, 0, 1, 4'b0011, 0, 4'b0000, 1, 1, 12'hF00, 0, 4'b0011, 0);
      applyStimulus(15, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0011, 1);
      // Bypass: write and frame_start together.
      applyStimulus(16, 1, 1, 4'b0000, 1, 4'b0001, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(17, 0, 1, 4'b0010, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(18, 0, 1, 4'b0011, 0, 4'b0000, 1, 0, 12'h00F, 0, 4'b0000, 0);
      applyStimulus(19, 0, 1, 4'b1111, 0, 4'b0000, 1, 0, 12'h00F, 0, 4'b0000, 0);
      applyStimulus(20, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(21, 0, 1, 4'b0000, 1, 4'b1111, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(22, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(23, 0, 1, 4'b0101, 0, 4'b0000, 1, 0, 12'h00F, 1, 4'b0000, 0);

      // Asynchronous reset between edges, with a collision pending in the accumulator.
      @(posedge clk);
      #2;
      resetN = 1'b1;
      #1;
      r = '{drawing: 1'b0, owner: 3'd0, rgb: 12'h000, coll_now: 1'b0,
            coll_frame: 4'b0000, coll_irq: 1'b0, tag: 8'd99};
      checkOutput(r);
      #1;
      resetN = 1'b0;

      applyStimulus(24, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);
      applyStimulus(25, 0, 1, 4'b1000, 0, 4'b0000, 1, 3, 12'h0F0, 0, 4'b0000, 0);
      applyStimulus(26, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 0, 4'b0000, 0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
